rob_param: RTL and testbench
============================

ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2.
REQ-002 SHALL have parameter NUM_WB, default 2, number of writeback channels.
REQ-003 SHALL have parameter XLEN, default 32, data/address width.
REQ-004 clk_in  input  1  system clock; the only clock.
REQ-005 rst_n_in  input  1  reset, synchronous, active-low.
REQ-006 rdy_in  input  1  global enable; all state holds when low.
REQ-007 iss_valid  input  1  decoder presents an instruction.
REQ-008 iss_ready  output  1  entry available (count < DEPTH) and flush low.
REQ-009 iss_rob_id  output  DEPTH_LOG2  tail index allocated to the presented instruction.
REQ-010 iss_type  input  2  00 BR, 01 ST, 10 JALR, 11 RG.
REQ-011 iss_rd / iss_pc / iss_aux  input  5 / XLEN / XLEN  destination, instruction address, predicted target (BR) or link value (JALR).
REQ-012 wb_valid / wb_rob_id / wb_value  input  NUM_WB / NUM_WB*DEPTH_LOG2 / NUM_WB*XLEN  packed writeback channels; channel k at slice k.
REQ-013 store_head  output  1  head is a busy ST entry not yet done (LSB may perform store).
REQ-014 commit_valid / commit_rob_id / commit_rd / commit_val / commit_pc  output  1 / DEPTH_LOG2 / 5 / XLEN / XLEN  register commit.
REQ-015 flush / flush_pc  output  1 / XLEN  mispredict redirect pulse and target.
REQ-016 resume / resume_pc  output  1 / XLEN  JALR redirect pulse and target.
REQ-017 count  output  DEPTH_LOG2+1  occupied entries.
REQ-018 srch_id_a, srch_id_b  input  DEPTH_LOG2; srch_ready_a/b  output 1; srch_val_a/b  output XLEN  operand lookup.

Function
REQ-019 Per entry: busy, done, type, rd, pc, aux, value; head/tail pointers wrap modulo DEPTH.
REQ-020 Full/empty SHALL derive from count; all DEPTH entries usable.
REQ-021 Issue fires when rdy_in && iss_valid && iss_ready: entry[tail] busy=1, done=0, value=0; tail+1.
REQ-022 Writeback k with wb_valid[k] sets done=1 and value=wb_value slice on a busy entry; non-busy target ignored; same id on two channels: lowest k wins.
REQ-023 Commit fires when entry[head] busy && done (registered state only): head+1, busy cleared; outputs registered, valid exactly one cycle later.
REQ-024 RG commit: commit_valid=1, commit_val=value. JALR: commit_valid=1, commit_val=aux, resume=1, resume_pc=value. BR/ST: commit_valid=0.
REQ-025 BR commit with value != aux: flush=1, flush_pc=value; otherwise no flush.
REQ-026 Cycle with flush=1 and rdy_in: all entries cleared, head=tail=count=0, issue/writeback/commit ignored, flush returns 0.
REQ-027 Issue and commit in the same cycle leave count unchanged; iss_ready SHALL NOT depend on same-cycle commit.
REQ-028 Non-commit cycles drive commit_valid=0, resume=0.
REQ-029 srch_ready = busy && done for the id; srch_val = stored value.

Reset
REQ-030 rst_n_in low at clk_in edge (regardless of rdy_in): all entries non-busy, pointers and count 0, every output register 0.
REQ-031 Reset mid-flush or mid-commit SHALL abort it; no pulse is emitted after reset.

Configuration
REQ-032 Macro ROB_WB_BYPASS_EN defined: search also matches same-cycle wb_valid channels (lowest k first, before stored state) for ready and value.
REQ-033 Macro undefined: search reflects registered state only; writeback visible one cycle later.

Verification
REQ-034 Reset, issue 16 RG (DEPTH_LOG2=4) -> count=16, iss_ready=0; 17th ignored; writeback id0 value 0x55 -> commit_val=0x55, commit_rob_id=0 one cycle after done.
REQ-035 Issue BR aux=0x100, writeback 0x200 -> flush=1, flush_pc=0x200 for one cycle; next cycle count=0, head=tail=0.
REQ-036 Issue JALR aux=0x1004, writeback 0x2000 -> commit_valid=1, commit_val=0x1004, resume=1, resume_pc=0x2000.
REQ-037 Fill/drain 40 instructions continuously -> pointers wrap, commits in program order, count never exceeds 16.
REQ-038 Writeback id3 value 0x7 while srch_id_a=3 -> srch_ready_a=1, srch_val_a=0x7 same cycle with ROB_WB_BYPASS_EN, next cycle without.
REQ-039 rdy_in low for 3 cycles during pending commit -> all outputs and count frozen; commit resumes after rdy_in high.

Source files
------------

// File: rtl/rob_param.sv
// rob_param: reorder buffer with in-order commit, branch-mispredict flush and JALR resume.
// Define ROB_WB_BYPASS_EN to let operand search also see same-cycle writebacks.
module rob_param #(
   parameter int DEPTH_LOG2 = 4,
   parameter int NUM_WB     = 2,
   parameter int XLEN       = 32
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic                         rdy_in,
   input  logic                         iss_valid,
   output logic                         iss_ready,
   output logic [DEPTH_LOG2-1:0]        iss_rob_id,
   input  logic [1:0]                   iss_type,
   input  logic [4:0]                   iss_rd,
   input  logic [XLEN-1:0]              iss_pc,
   input  logic [XLEN-1:0]              iss_aux,
   input  logic [NUM_WB-1:0]            wb_valid,
   input  logic [NUM_WB*DEPTH_LOG2-1:0] wb_rob_id,
   input  logic [NUM_WB*XLEN-1:0]       wb_value,
   output logic                         store_head,
   output logic                         commit_valid,
   output logic [DEPTH_LOG2-1:0]        commit_rob_id,
   output logic [4:0]                   commit_rd,
   output logic [XLEN-1:0]              commit_val,
   output logic [XLEN-1:0]              commit_pc,
   output logic                         flush,
   output logic [XLEN-1:0]              flush_pc,
   output logic                         resume,
   output logic [XLEN-1:0]              resume_pc,
   output logic [DEPTH_LOG2:0]          count,
   input  logic [DEPTH_LOG2-1:0]        srch_id_a,
   input  logic [DEPTH_LOG2-1:0]        srch_id_b,
   output logic                         srch_ready_a,
   output logic                         srch_ready_b,
   output logic [XLEN-1:0]              srch_val_a,
   output logic [XLEN-1:0]              srch_val_b
);
   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [1:0] T_BR = 2'b00, T_ST = 2'b01, T_JALR = 2'b10, T_RG = 2'b11;

   logic                  r_busy [DEPTH];
   logic                  r_done [DEPTH];
   logic [1:0]            r_type [DEPTH];
   logic [4:0]            r_rd   [DEPTH];
   logic [XLEN-1:0]       r_pc   [DEPTH];
   logic [XLEN-1:0]       r_aux  [DEPTH];
   logic [XLEN-1:0]       r_val  [DEPTH];
   logic [DEPTH_LOG2-1:0] r_head, r_tail, r_crid;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_flush, r_cv, r_resume;
   logic [4:0]            r_crd;
   logic [XLEN-1:0]       r_cval, r_cpc, r_fpc, r_rpc;
   logic                  w_iss, w_com;

   // count never exceeds DEPTH, so its MSB alone flags a full buffer
   assign iss_ready     = !r_count[DEPTH_LOG2] && !r_flush;
   assign iss_rob_id    = r_tail;
   assign w_iss         = rdy_in && iss_valid && iss_ready;
   assign w_com         = r_busy[r_head] && r_done[r_head];
   assign store_head    = r_busy[r_head] && !r_done[r_head] && r_type[r_head] == T_ST;
   assign count         = r_count;
   assign flush         = r_flush;
   assign flush_pc      = r_fpc;
   assign resume        = r_resume;
   assign resume_pc     = r_rpc;
   assign commit_valid  = r_cv;
   assign commit_rob_id = r_crid;
   assign commit_rd     = r_crd;
   assign commit_val    = r_cval;
   assign commit_pc     = r_cpc;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_busy[i] <= 1'b0;
            r_done[i] <= 1'b0;
         end
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_flush  <= 1'b0;
         r_cv     <= 1'b0;
         r_resume <= 1'b0;
         r_crid   <= '0;
         r_crd    <= '0;
         r_cval   <= '0;
         r_cpc    <= '0;
         r_fpc    <= '0;
         r_rpc    <= '0;
      end else if (rdy_in) begin
         if (r_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_busy[i] <= 1'b0;
               r_done[i] <= 1'b0;
            end
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_flush  <= 1'b0;
            r_cv     <= 1'b0;
            r_resume <= 1'b0;
         end else begin
            // descending loop so the lowest channel's write lands last and wins
            for (int k = NUM_WB-1; k >= 0; k--) begin
               if (wb_valid[k] && r_busy[wb_rob_id[k*DEPTH_LOG2 +: DEPTH_LOG2]]) begin
                  r_done[wb_rob_id[k*DEPTH_LOG2 +: DEPTH_LOG2]] <= 1'b1;
                  r_val[wb_rob_id[k*DEPTH_LOG2 +: DEPTH_LOG2]]  <= wb_value[k*XLEN +: XLEN];
               end
            end
            r_cv     <= w_com && (r_type[r_head] == T_RG || r_type[r_head] == T_JALR);
            r_resume <= w_com && r_type[r_head] == T_JALR;
            r_flush  <= w_com && r_type[r_head] == T_BR && r_val[r_head] != r_aux[r_head];
            if (w_com) begin
               r_busy[r_head] <= 1'b0;
               r_done[r_head] <= 1'b0;
               r_head         <= r_head + DEPTH_LOG2'(1);
               r_crid         <= r_head;
               r_crd          <= r_rd[r_head];
               r_cpc          <= r_pc[r_head];
               r_cval         <= r_type[r_head] == T_JALR ? r_aux[r_head] : r_val[r_head];
               r_fpc          <= r_type[r_head] == T_BR ? r_val[r_head] : r_fpc;
               r_rpc          <= r_type[r_head] == T_JALR ? r_val[r_head] : r_rpc;
            end
            if (w_iss) begin
               r_busy[r_tail] <= 1'b1;
               r_done[r_tail] <= 1'b0;
               r_val[r_tail]  <= '0;
               r_type[r_tail] <= iss_type;
               r_rd[r_tail]   <= iss_rd;
               r_pc[r_tail]   <= iss_pc;
               r_aux[r_tail]  <= iss_aux;
               r_tail         <= r_tail + DEPTH_LOG2'(1);
            end
            r_count <= r_count + (DEPTH_LOG2+1)'(w_iss) - (DEPTH_LOG2+1)'(w_com);
         end
      end
   end

   always_comb begin
      srch_ready_a = r_busy[srch_id_a] && r_done[srch_id_a];
      srch_val_a   = r_val[srch_id_a];
      srch_ready_b = r_busy[srch_id_b] && r_done[srch_id_b];
      srch_val_b   = r_val[srch_id_b];
`ifdef ROB_WB_BYPASS_EN
      for (int k = NUM_WB-1; k >= 0; k--) begin
         if (wb_valid[k] && r_busy[srch_id_a] && wb_rob_id[k*DEPTH_LOG2 +: DEPTH_LOG2] == srch_id_a) begin
            srch_ready_a = 1'b1;
            srch_val_a   = wb_value[k*XLEN +: XLEN];
         end
         if (wb_valid[k] && r_busy[srch_id_b] && wb_rob_id[k*DEPTH_LOG2 +: DEPTH_LOG2] == srch_id_b) begin
            srch_ready_b = 1'b1;
            srch_val_b   = wb_value[k*XLEN +: XLEN];
         end
      end
`endif
   end
endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed and random checks of rob_param against a queue-based program-order model.
module tb_rob_param;
   localparam int DL = 4, NW = 2, XL = 32, DEPTH = 16;
   localparam logic [1:0] BR = 2'b00, ST = 2'b01, JALR = 2'b10, RG = 2'b11;
`ifdef ROB_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n, rdy, iss_valid, iss_ready, store_head, commit_valid, flush, resume;
   logic srch_ready_a, srch_ready_b;
   logic [1:0] iss_type;
   logic [4:0] iss_rd, commit_rd;
   logic [DL-1:0] iss_rob_id, commit_rob_id, srch_id_a, srch_id_b;
   logic [DL:0] count;
   logic [XL-1:0] iss_pc, iss_aux, commit_val, commit_pc, flush_pc, resume_pc, srch_val_a, srch_val_b;
   logic [NW-1:0] wb_valid;
   logic [NW*DL-1:0] wb_rob_id;
   logic [NW*XL-1:0] wb_value;

   rob_param #(.DEPTH_LOG2(DL), .NUM_WB(NW), .XLEN(XL)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rob_id(iss_rob_id),
      .iss_type(iss_type), .iss_rd(iss_rd), .iss_pc(iss_pc), .iss_aux(iss_aux),
      .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
      .store_head(store_head), .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
      .commit_rd(commit_rd), .commit_val(commit_val), .commit_pc(commit_pc),
      .flush(flush), .flush_pc(flush_pc), .resume(resume), .resume_pc(resume_pc),
      .count(count), .srch_id_a(srch_id_a), .srch_id_b(srch_id_b),
      .srch_ready_a(srch_ready_a), .srch_ready_b(srch_ready_b),
      .srch_val_a(srch_val_a), .srch_val_b(srch_val_b)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  id;
      logic [1:0]  ty;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] aux;
      logic [31:0] val;
      logic        done;
   } ent_t;

   ent_t q[$];
   logic [3:0] tail_id = '0;
   bit e_cv, e_flush, e_resume;
   logic [3:0] e_rid;
   logic [4:0] e_rd;
   logic [31:0] e_val, e_pc, e_fpc, e_rpc;
   int n_pushed = 0;
   int errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_q(input logic [3:0] id);
      foreach (q[i]) if (q[i].id == id) return 1'b1;
      return 1'b0;
   endfunction

   // the model keeps in-flight instructions in program order; head is q[0]
   task automatic model_step();
      ent_t h, e;
      bit com, iss;
      bit claimed [16];
      if (!rst_n) begin
         q.delete();
         tail_id = '0;
         e_cv = 0; e_flush = 0; e_resume = 0;
         return;
      end
      if (!rdy) return;
      if (e_flush) begin
         q.delete();
         tail_id = '0;
         e_cv = 0; e_flush = 0; e_resume = 0;
         return;
      end
      com = (q.size() > 0) ? q[0].done : 1'b0;
      iss = iss_valid && q.size() < DEPTH;
      if (com) h = q[0];
      foreach (claimed[i]) claimed[i] = 1'b0;
      for (int k = 0; k < NW; k++) begin
         if (wb_valid[k] && !claimed[wb_rob_id[k*DL +: DL]]) begin
            claimed[wb_rob_id[k*DL +: DL]] = 1'b1;
            foreach (q[i]) if (q[i].id == wb_rob_id[k*DL +: DL]) begin
               e = q[i];
               e.done = 1'b1;
               e.val = wb_value[k*XL +: XL];
               q[i] = e;
            end
         end
      end
      e_cv = com && (h.ty == RG || h.ty == JALR);
      e_resume = com && h.ty == JALR;
      e_flush = com && h.ty == BR && h.val != h.aux;
      if (com) begin
         q.delete(0);
         e_rid = h.id; e_rd = h.rd; e_pc = h.pc;
         e_val = (h.ty == JALR) ? h.aux : h.val;
         e_fpc = h.val; e_rpc = h.val;
      end
      if (iss) begin
         e = '{id: tail_id, ty: iss_type, rd: iss_rd, pc: iss_pc, aux: iss_aux, val: 32'h0, done: 1'b0};
         q.push_back(e);
         tail_id++;
         n_pushed++;
      end
   endtask

   task automatic srch_exp(input logic [3:0] id, output bit r, output logic [31:0] v);
      r = 0; v = '0;
      foreach (q[i]) if (q[i].id == id && q[i].done) begin r = 1; v = q[i].val; end
      if (BYP) begin
         for (int k = NW-1; k >= 0; k--)
            if (wb_valid[k] && wb_rob_id[k*DL +: DL] == id && in_q(id)) begin r = 1; v = wb_value[k*XL +: XL]; end
      end
   endtask

   task automatic check_all();
      bit ra, rb;
      logic [31:0] va, vb;
      chk("count", count, q.size());
      chk("iss_ready", iss_ready, q.size() < DEPTH && !e_flush);
      chk("iss_rob_id", iss_rob_id, tail_id);
      chk("commit_valid", commit_valid, e_cv);
      chk("flush", flush, e_flush);
      chk("resume", resume, e_resume);
      chk("store_head", store_head, (q.size() > 0) ? (q[0].ty == ST && !q[0].done) : 1'b0);
      if (e_cv) begin
         chk("commit_rob_id", commit_rob_id, e_rid);
         chk("commit_rd", commit_rd, e_rd);
         chk("commit_pc", commit_pc, e_pc);
         chk("commit_val", commit_val, e_val);
      end
      if (e_flush) chk("flush_pc", flush_pc, e_fpc);
      if (e_resume) chk("resume_pc", resume_pc, e_rpc);
      srch_exp(srch_id_a, ra, va);
      srch_exp(srch_id_b, rb, vb);
      chk("srch_ready_a", srch_ready_a, ra);
      chk("srch_ready_b", srch_ready_b, rb);
      if (ra) chk("srch_val_a", srch_val_a, va);
      if (rb) chk("srch_val_b", srch_val_b, vb);
   endtask

   task automatic cyc();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic put(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] aux);
      iss_valid = 1'b1; iss_type = t; iss_rd = rd; iss_pc = pc; iss_aux = aux;
   endtask

   task automatic set_wb(input int k, input logic [3:0] id, input logic [31:0] v);
      wb_valid[k] = 1'b1;
      wb_rob_id[k*DL +: DL] = id;
      wb_value[k*XL +: XL] = v;
   endtask

   task automatic rand_phase(input int n_issue, input bit allow_mis, input int budget, output int max_c);
      int start, n;
      logic [3:0] id;
      logic [31:0] v;
      int idx;
      start = n_pushed;
      n = 0;
      max_c = 0;
      while ((n_pushed - start < n_issue || q.size() > 0) && n < budget) begin
         rdy = ($urandom_range(0, 9) != 0);
         rst_n = !(allow_mis && $urandom_range(0, 59) == 0);
         iss_valid = (n_pushed - start < n_issue) && $urandom_range(0, 3) != 0;
         iss_type = 2'($urandom); iss_rd = 5'($urandom); iss_pc = $urandom; iss_aux = $urandom;
         srch_id_a = 4'($urandom); srch_id_b = 4'($urandom);
         wb_valid = '0;
         for (int k = 0; k < NW; k++) begin
            if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
               idx = $urandom_range(0, q.size() - 1);
               id = q[idx].id;
               v = $urandom;
               if (q[idx].ty == BR) v = (allow_mis && $urandom_range(0, 3) == 0) ? ~q[idx].aux : q[idx].aux;
               if (k == 1 && wb_valid[0] && $urandom_range(0, 3) == 0) id = wb_rob_id[DL-1:0];
               if (allow_mis && $urandom_range(0, 7) == 0) id = 4'($urandom);
               set_wb(k, id, v);
               if (k == 1 && wb_valid[0] && id == wb_rob_id[DL-1:0]) srch_id_a = id;
            end
         end
         cyc();
         if (int'(count) > max_c) max_c = int'(count);
         n++;
      end
      rst_n = 1; rdy = 1; iss_valid = 0; wb_valid = '0;
      chk("phase_drained", q.size(), 0);
   endtask

   initial begin
      int mx;
      rst_n = 0; rdy = 1; iss_valid = 0; iss_type = RG; iss_rd = '0; iss_pc = '0; iss_aux = '0;
      wb_valid = '0; wb_rob_id = '0; wb_value = '0; srch_id_a = '0; srch_id_b = '0;
      repeat (2) begin @(posedge clk); model_step(); end
      #1;
      chk("rst_count", count, 0);
      chk("rst_iss_ready", iss_ready, 1);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_commit_val", commit_val, 0);
      chk("rst_flush", flush, 0);
      chk("rst_resume", resume, 0);
      chk("rst_store_head", store_head, 0);
      chk("rst_srch_ready_a", srch_ready_a, 0);
      rst_n = 1;

      // fill to capacity; the 17th issue must be refused
      for (int i = 0; i < 17; i++) begin
         put(RG, 5'(i + 1), 32'h1000 + 32'(i * 4), 32'h0);
         cyc();
      end
      iss_valid = 0;
      chk("full_count", count, 16);
      chk("full_iss_ready", iss_ready, 0);
      chk("full_tail_wrapped", iss_rob_id, 0);
      set_wb(0, 4'd0, 32'h55);
      cyc();
      wb_valid = '0;
      cyc();
      chk("c0_valid", commit_valid, 1);
      chk("c0_val", commit_val, 32'h55);
      chk("c0_rob_id", commit_rob_id, 0);
      chk("c0_pc", commit_pc, 32'h1000);
      chk("c0_count", count, 15);

      // branch mispredict
      rst_n = 0; cyc(); rst_n = 1;
      put(BR, 5'd0, 32'h40, 32'h100);
      cyc();
      iss_valid = 0;
      set_wb(0, 4'd0, 32'h200);
      cyc();
      wb_valid = '0;
      cyc();
      chk("br_flush", flush, 1);
      chk("br_flush_pc", flush_pc, 32'h200);
      chk("br_commit_valid", commit_valid, 0);
      chk("br_iss_ready_in_flush", iss_ready, 0);
      cyc();
      chk("br_flush_clear", flush, 0);
      chk("br_count", count, 0);
      chk("br_tail", iss_rob_id, 0);

      // JALR resume, written back on channel 1
      put(JALR, 5'd1, 32'h80, 32'h1004);
      cyc();
      iss_valid = 0;
      set_wb(1, 4'd0, 32'h2000);
      cyc();
      wb_valid = '0;
      cyc();
      chk("jalr_commit_valid", commit_valid, 1);
      chk("jalr_commit_val", commit_val, 32'h1004);
      chk("jalr_resume", resume, 1);
      chk("jalr_resume_pc", resume_pc, 32'h2000);
      cyc();
      chk("jalr_resume_pulse", resume, 0);

      // operand search visibility of a writeback
      rst_n = 0; cyc(); rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         put(RG, 5'(i + 3), 32'h200 + 32'(i * 4), 32'h0);
         cyc();
      end
      iss_valid = 0;
      srch_id_a = 4'd3;
      set_wb(1, 4'd3, 32'h7);
      #1;
      chk("byp_same_cycle_ready", srch_ready_a, BYP);
      cyc();
      wb_valid = '0;
      #1;
      chk("srch_next_ready", srch_ready_a, 1);
      chk("srch_next_val", srch_val_a, 32'h7);

      // stall with a commit pending
      set_wb(0, 4'd0, 32'h11);
      cyc();
      wb_valid = '0;
      rdy = 0;
      put(RG, 5'd9, 32'h300, 32'h0);
      repeat (3) cyc();
      chk("frz_count", count, 5);
      chk("frz_commit_valid", commit_valid, 0);
      chk("frz_tail", iss_rob_id, 5);
      iss_valid = 0;
      rdy = 1;
      cyc();
      chk("thaw_commit_valid", commit_valid, 1);
      chk("thaw_commit_val", commit_val, 32'h11);
      chk("thaw_count", count, 4);

      // continuous fill/drain without mispredicts, then mixed traffic with flushes and resets
      rst_n = 0; cyc(); rst_n = 1;
      rand_phase(40, 1'b0, 3000, mx);
      chk("max_count_le_depth", mx <= DEPTH, 1);
      rand_phase(150, 1'b1, 6000, mx);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
